// File: rtl/debug_dump_tx.sv
// Debug-link UART reporter: streams A5, PC, REGS, MEM, LATCH words (MSB byte first), 5A over 8N1 TX.
// Word FSM walks the debug read ports; an internal byte transmitter paces it through a load/tx_done handshake.
module debug_dump_tx #(
   parameter int CLK_DIV     = 868,
   parameter int N_REGS      = 32,
   parameter int MEM_WORDS   = 32,
   parameter int LATCH_WORDS = 20,
   parameter int SETTLE      = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] inPC,
   input  logic [31:0] inFRData,
   input  logic [31:0] inMemData,
   input  logic [31:0] inLatch,
   output logic [31:0] outDebugAddress,
   output logic [6:0]  outControlLatchMux,
   output logic        out_debug_on,
   output logic        busy,
   output logic        done,
   output logic        TX
);

   localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_SET, S_WAIT, S_CAP, S_SEND, S_TRL, S_DONE
   } state_t;

   typedef enum logic [1:0] {
      PH_PC, PH_REG, PH_MEM, PH_LAT
   } phase_t;

   state_t      state_q;
   phase_t      phase_q;
   logic [31:0] idx_q;
   logic [31:0] pc_q;
   logic [31:0] word_q;
   logic [2:0]  byte_q;
   logic [7:0]  wait_q;
   logic        busy_q;
   logic        done_q;
   logic [31:0] addr_q;
   logic [6:0]  mux_q;

   logic             tx_q;
   logic             tx_busy_q;
   logic [DIV_W-1:0] div_q;
   logic [3:0]       bit_q;
   logic [7:0]       sh_q;
   logic             tx_done;

   logic        ld_d;
   logic [7:0]  ld_byte_d;
   logic [31:0] cap_word;
   phase_t      adv_ph;
   logic [31:0] adv_idx;
   logic        adv_trl;

   assign outDebugAddress    = addr_q;
   assign outControlLatchMux = mux_q;
   assign out_debug_on       = busy_q;
   assign busy               = busy_q;
   assign done               = done_q;
   assign TX                 = tx_q;

   assign tx_done = tx_busy_q && (bit_q == 4'd9) && (div_q == DIV_W'(CLK_DIV - 1));

   always_comb begin
      cap_word = inLatch;
      case (phase_q)
         PH_PC:   cap_word = pc_q;
         PH_REG:  cap_word = inFRData;
         PH_MEM:  cap_word = inMemData;
         default: cap_word = inLatch;
      endcase
   end

   // Next word after the current one: stay in phase, or fall through empty phases to the trailer.
   always_comb begin
      adv_trl = 1'b0;
      adv_ph  = phase_q;
      adv_idx = idx_q + 32'd1;
      case (phase_q)
         PH_PC: begin
            adv_idx = '0;
            if (N_REGS > 0)           adv_ph  = PH_REG;
            else if (MEM_WORDS > 0)   adv_ph  = PH_MEM;
            else if (LATCH_WORDS > 0) adv_ph  = PH_LAT;
            else                      adv_trl = 1'b1;
         end
         PH_REG: begin
            if (idx_q == 32'(N_REGS - 1)) begin
               adv_idx = '0;
               if (MEM_WORDS > 0)        adv_ph  = PH_MEM;
               else if (LATCH_WORDS > 0) adv_ph  = PH_LAT;
               else                      adv_trl = 1'b1;
            end
         end
         PH_MEM: begin
            if (idx_q == 32'(MEM_WORDS - 1)) begin
               adv_idx = '0;
               if (LATCH_WORDS > 0) adv_ph  = PH_LAT;
               else                 adv_trl = 1'b1;
            end
         end
         default: begin
            if (idx_q == 32'(LATCH_WORDS - 1)) adv_trl = 1'b1;
         end
      endcase
   end

   always_comb begin
      ld_d      = 1'b0;
      ld_byte_d = word_q[31:24];
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               ld_d      = 1'b1;
               ld_byte_d = 8'hA5;
            end
         end
         S_CAP: begin
            ld_d      = 1'b1;
            ld_byte_d = cap_word[31:24];
         end
         S_SEND: begin
            if (byte_q != 3'd4 && !tx_busy_q) ld_d = 1'b1;
         end
         S_TRL: begin
            if (byte_q == 3'd0) begin
               ld_d      = 1'b1;
               ld_byte_d = 8'h5A;
            end
         end
         default: ld_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_q      <= 1'b1;
         tx_busy_q <= 1'b0;
         div_q     <= '0;
         bit_q     <= '0;
         sh_q      <= '0;
      end else if (ld_d && !tx_busy_q) begin
         tx_q      <= 1'b0;
         tx_busy_q <= 1'b1;
         div_q     <= '0;
         bit_q     <= '0;
         sh_q      <= ld_byte_d;
      end else if (tx_busy_q) begin
         if (div_q == DIV_W'(CLK_DIV - 1)) begin
            div_q <= '0;
            if (bit_q == 4'd9) begin
               tx_busy_q <= 1'b0;
               tx_q      <= 1'b1;
            end else begin
               bit_q <= bit_q + 4'd1;
               if (bit_q == 4'd8) begin
                  tx_q <= 1'b1;
               end else begin
                  tx_q <= sh_q[0];
                  sh_q <= {1'b0, sh_q[7:1]};
               end
            end
         end else begin
            div_q <= div_q + DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         phase_q <= PH_PC;
         idx_q   <= '0;
         pc_q    <= '0;
         word_q  <= '0;
         byte_q  <= '0;
         wait_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         addr_q  <= '0;
         mux_q   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_q <= S_HDR;
                  busy_q  <= 1'b1;
                  pc_q    <= inPC;
                  phase_q <= PH_PC;
                  idx_q   <= '0;
                  addr_q  <= '0;
                  mux_q   <= '0;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_HDR: begin
               if (tx_done) state_q <= S_CAP;
            end
            S_SET: begin
               wait_q  <= '0;
               state_q <= (SETTLE > 1) ? S_WAIT : S_CAP;
            end
            S_WAIT: begin
               if (wait_q == 8'(SETTLE - 2)) state_q <= S_CAP;
               else                          wait_q  <= wait_q + 8'd1;
            end
            S_CAP: begin
               // First byte leaves straight from the read port; the rest are shifted up.
               word_q  <= {cap_word[23:0], 8'h00};
               byte_q  <= 3'd1;
               state_q <= S_SEND;
            end
            S_SEND: begin
               if (byte_q != 3'd4) begin
                  if (!tx_busy_q) begin
                     byte_q <= byte_q + 3'd1;
                     word_q <= {word_q[23:0], 8'h00};
                  end
               end else if (tx_done) begin
                  if (adv_trl) begin
                     state_q <= S_TRL;
                     byte_q  <= 3'd0;
                     addr_q  <= '0;
                     mux_q   <= '0;
                  end else begin
                     state_q <= S_SET;
                     phase_q <= adv_ph;
                     idx_q   <= adv_idx;
                     addr_q  <= (adv_ph == PH_LAT) ? 32'd0 : adv_idx;
                     mux_q   <= (adv_ph == PH_LAT) ? adv_idx[6:0] : 7'd0;
                  end
               end
            end
            S_TRL: begin
               if (byte_q == 3'd0) begin
                  byte_q <= 3'd1;
               end else if (tx_done) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
